// File: rtl/frac_pwm_meas.sv
// Fractional PWM receiver: measures the period and sums high times over frames
// of 2^FSZE periods, giving duty in integer.FSZE fixed point.
module frac_pwm_meas #(
    parameter int WIDTH = 17,
    parameter int FSZE  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  pwm_in,
    output logic [WIDTH-1:0]      period,
    output logic                  period_valid,
    output logic [WIDTH+FSZE-1:0] duty_fx,
    output logic                  frame_valid,
    output logic                  timeout,
    output logic                  level
);

    // state  | meaning
    // S_IDLE | waiting for a rise to start measuring
    // S_HIGH | input high, counting period and high time
    // S_LOW  | input low, counting period; a rise closes it
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    localparam int AW = WIDTH + FSZE;
    localparam logic [WIDTH-1:0] PMAX  = '1;
    localparam logic [FSZE-1:0]  FLAST = '1;

    state_t state_q, state_d;

    logic sync1_q, pwm_s_q, pwm_d_q;
    logic rise, fall;

    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] hlast_q, hlast_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [FSZE-1:0]  fidx_q, fidx_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [AW-1:0]    duty_q, duty_d;
    logic             pv_q, pv_d;
    logic             fv_q, fv_d;
    logic             timeout_q, timeout_d;
    logic             level_q, level_d;
    logic [AW-1:0]    sum;

    assign rise = pwm_s_q & ~pwm_d_q;
    assign fall = ~pwm_s_q & pwm_d_q;
    assign sum  = acc_q + {{FSZE{1'b0}}, hlast_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            pwm_s_q   <= 1'b0;
            pwm_d_q   <= 1'b0;
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            hlast_q   <= '0;
            acc_q     <= '0;
            fidx_q    <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            pv_q      <= 1'b0;
            fv_q      <= 1'b0;
            timeout_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            sync1_q   <= pwm_in;
            pwm_s_q   <= sync1_q;
            pwm_d_q   <= pwm_s_q;
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            hcnt_q    <= hcnt_d;
            hlast_q   <= hlast_d;
            acc_q     <= acc_d;
            fidx_q    <= fidx_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            pv_q      <= pv_d;
            fv_q      <= fv_d;
            timeout_q <= timeout_d;
            level_q   <= level_d;
        end
    end

    // A counter at full scale means no closing rise arrived in time.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (rise) state_d = S_HIGH;
                S_HIGH: begin
                    if (pcnt_q == PMAX)  state_d = S_IDLE;
                    else if (fall)       state_d = S_LOW;
                end
                S_LOW: begin
                    if (rise)                 state_d = S_HIGH;
                    else if (pcnt_q == PMAX)  state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pcnt_d    = pcnt_q;
        hcnt_d    = hcnt_q;
        hlast_d   = hlast_q;
        acc_d     = acc_q;
        fidx_d    = fidx_q;
        period_d  = period_q;
        duty_d    = duty_q;
        pv_d      = 1'b0;
        fv_d      = 1'b0;
        timeout_d = timeout_q;
        level_d   = level_q;
        if (!en) begin
            acc_d  = '0;
            fidx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        pcnt_d    = WIDTH'(1);
                        hcnt_d    = WIDTH'(1);
                        acc_d     = '0;
                        fidx_d    = '0;
                        timeout_d = 1'b0;
                    end
                end
                S_HIGH: begin
                    if (pcnt_q == PMAX) begin
                        timeout_d = 1'b1;
                        level_d   = pwm_s_q;
                        acc_d     = '0;
                        fidx_d    = '0;
                    end else begin
                        pcnt_d = pcnt_q + WIDTH'(1);
                        hcnt_d = hcnt_q + WIDTH'(1);
                        if (fall) hlast_d = hcnt_q;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        period_d = pcnt_q;
                        pv_d     = 1'b1;
                        acc_d    = sum;
                        fidx_d   = fidx_q + FSZE'(1);
                        if (fidx_q == FLAST) begin
                            duty_d = sum;
                            fv_d   = 1'b1;
                            acc_d  = '0;
                        end
                        pcnt_d = WIDTH'(1);
                        hcnt_d = WIDTH'(1);
                    end else if (pcnt_q == PMAX) begin
                        timeout_d = 1'b1;
                        level_d   = pwm_s_q;
                        acc_d     = '0;
                        fidx_d    = '0;
                    end else begin
                        pcnt_d = pcnt_q + WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign duty_fx      = duty_q;
    assign frame_valid  = fv_q;
    assign timeout      = timeout_q;
    assign level        = level_q;

endmodule

// File: tb/tb_frac_pwm_meas.sv
// Directed bench for frac_pwm_meas: frame vectors from a table plus
// timeout, enable and reset sequences.
module tb_frac_pwm_meas;
    localparam int W = 8;
    localparam int F = 3;

    logic clk = 1'b0;
    logic rst, en, pwm_in;
    logic [W-1:0]   period;
    logic           period_valid;
    logic [W+F-1:0] duty_fx;
    logic           frame_valid;
    logic           timeout;
    logic           level;

    frac_pwm_meas #(.WIDTH(W), .FSZE(F)) dut (
        .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
        .period(period), .period_valid(period_valid),
        .duty_fx(duty_fx), .frame_valid(frame_valid),
        .timeout(timeout), .level(level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pv_cnt = 0;
    int fv_cnt = 0;
    int last_per = 0;
    int last_duty = 0;
    int exp_per = 0;
    bit chk_per = 0;
    logic pv_prev = 1'b0;
    logic fv_prev = 1'b0;

    typedef struct {
        int per;
        int hi_a;
        int n_a;
        int hi_b;
        int exp_duty;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen(input int hi, input int per);
        pwm_in = 1'b1;
        tick(hi);
        pwm_in = 1'b0;
        tick(per - hi);
    endtask

    task automatic run_frame(input int per, input int hi_a, input int n_a, input int hi_b);
        for (int i = 0; i < 8; i++) gen((i < n_a) ? hi_a : hi_b, per);
    endtask

    always @(posedge clk) begin
        #1;
        if (period_valid) begin
            pv_cnt++;
            last_per = int'(period);
            check("pv_width", int'(pv_prev), 0);
            if (chk_per) check("period", int'(period), exp_per);
        end
        if (frame_valid) begin
            fv_cnt++;
            last_duty = int'(duty_fx);
            check("fv_width", int'(fv_prev), 0);
            check("fv_with_pv", int'(period_valid), 1);
        end
        pv_prev = period_valid;
        fv_prev = frame_valid;
    end

    initial begin
        int pv0, fv0;
        vecs[0] = '{per: 100, hi_a: 10,  n_a: 8, hi_b: 10,  exp_duty: 80};
        vecs[1] = '{per: 100, hi_a: 11,  n_a: 3, hi_b: 10,  exp_duty: 83};
        vecs[2] = '{per: 2,   hi_a: 1,   n_a: 8, hi_b: 1,   exp_duty: 8};
        vecs[3] = '{per: 20,  hi_a: 19,  n_a: 8, hi_b: 19,  exp_duty: 152};
        vecs[4] = '{per: 50,  hi_a: 25,  n_a: 4, hi_b: 26,  exp_duty: 204};
        vecs[5] = '{per: 254, hi_a: 200, n_a: 8, hi_b: 200, exp_duty: 1600};

        rst = 1'b1;
        en = 1'b0;
        pwm_in = 1'b0;
        tick(3);
        check("rst_period", int'(period), 0);
        check("rst_duty", int'(duty_fx), 0);
        check("rst_pv", int'(period_valid), 0);
        check("rst_fv", int'(frame_valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_level", int'(level), 0);
        rst = 1'b0;
        tick(2);

        foreach (vecs[k]) begin
            exp_per = vecs[k].per;
            chk_per = 1;
            pv0 = pv_cnt;
            fv0 = fv_cnt;
            en = 1'b1;
            run_frame(vecs[k].per, vecs[k].hi_a, vecs[k].n_a, vecs[k].hi_b);
            check("no_early_frame", fv_cnt, fv0);
            pwm_in = 1'b1;
            tick(6);
            check("frame_count", fv_cnt, fv0 + 1);
            check("duty_fx", last_duty, vecs[k].exp_duty);
            check("period_count", pv_cnt, pv0 + 8);
            en = 1'b0;
            tick(2);
            pwm_in = 1'b0;
            tick(4);
        end

        // 0% duty timeout, then 100% duty timeout
        chk_per = 0;
        pv0 = pv_cnt;
        en = 1'b1;
        gen(10, 300);
        check("to0_timeout", int'(timeout), 1);
        check("to0_level", int'(level), 0);
        check("to0_no_period", pv_cnt, pv0);
        pwm_in = 1'b1;
        tick(10);
        check("to_cleared", int'(timeout), 0);
        tick(240);
        check("to1_not_yet", int'(timeout), 0);
        tick(12);
        check("to1_timeout", int'(timeout), 1);
        check("to1_level", int'(level), 1);
        pwm_in = 1'b0;
        tick(5);
        exp_per = 100;
        chk_per = 1;
        pv0 = pv_cnt;
        fv0 = fv_cnt;
        run_frame(100, 10, 8, 10);
        check("to_restart_no_frame", fv_cnt, fv0);
        check("to_restart_timeout", int'(timeout), 0);
        pwm_in = 1'b1;
        tick(6);
        check("to_restart_frame", fv_cnt, fv0 + 1);
        check("to_restart_duty", last_duty, 80);
        check("to_restart_pcount", pv_cnt, pv0 + 8);
        en = 1'b0;
        tick(2);
        pwm_in = 1'b0;
        tick(4);

        // enable dropped mid-frame
        en = 1'b1;
        for (int i = 0; i < 5; i++) gen(11, 100);
        pv0 = pv_cnt;
        fv0 = fv_cnt;
        en = 1'b0;
        gen(11, 100);
        gen(11, 100);
        check("en_off_no_period", pv_cnt, pv0);
        check("en_off_no_frame", fv_cnt, fv0);
        en = 1'b1;
        run_frame(100, 10, 8, 10);
        check("en_partial_no_frame", fv_cnt, fv0);
        pwm_in = 1'b1;
        tick(6);
        check("en_frame", fv_cnt, fv0 + 1);
        check("en_duty", last_duty, 80);
        en = 1'b0;
        tick(2);
        pwm_in = 1'b0;
        tick(4);

        // async reset in the middle of a high phase
        en = 1'b1;
        pwm_in = 1'b1;
        tick(5);
        #3;
        rst = 1'b1;
        #1;
        check("arst_period", int'(period), 0);
        check("arst_duty", int'(duty_fx), 0);
        check("arst_pv", int'(period_valid), 0);
        check("arst_timeout", int'(timeout), 0);
        check("arst_level", int'(level), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_per = 0;
        pv0 = pv_cnt;
        fv0 = fv_cnt;
        tick(5);
        pwm_in = 1'b0;
        tick(90);
        check("arst_first_rise_unreported", pv_cnt, pv0);
        run_frame(100, 10, 8, 10);
        pwm_in = 1'b1;
        tick(6);
        check("arst_frame", fv_cnt, fv0 + 1);
        check("arst_period_after", last_per, 100);
        pwm_in = 1'b0;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
